// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isa_pkg
//  Description : Shared ISA definitions for the front end: opcode values,
//                instruction width, fetch FSM state encodings, the
//                instruction-buffer entry type and opcode helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

    localparam int INST_W = 32;

    localparam logic [5:0] OP_JMP  = 6'b001100;
    localparam logic [5:0] OP_CALL = 6'b001101;
    localparam logic [5:0] OP_PUSH = 6'b001111;
    localparam logic [5:0] OP_POP  = 6'b010000;

    // Fetch FSM encodings
    localparam int          STATE_W   = 2;
    localparam logic [1:0]  ST_BOOT   = 2'd0;
    localparam logic [1:0]  ST_RUN    = 2'd1;
    localparam logic [1:0]  ST_HALTED = 2'd2;

    // One instruction-buffer slot: word address tag plus instruction word
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic is_jmp(input logic [5:0] opcode);
        return (opcode == OP_JMP);
    endfunction

    // Absolute jump target: keep the region bits of the JMP's own address
    function automatic logic [31:0] jmp_target(input logic [5:0]  pc_hi,
                                               input logic [25:0] offset);
        return {pc_hi, offset};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundle of all fetch-unit bus signals: instruction-memory
//                request/response, control-flow redirect, halt and the
//                fetch-to-decode handshake.
//  Ports       : imem_req/imem_addr        fetch -> memory request
//                imem_rvalid/imem_rdata    memory -> fetch response (1 cycle)
//                redirect_valid/redirect_pc later stages -> fetch
//                halt                      stop issuing requests
//                if_valid/if_pc/if_inst    fetch -> decode
//                id_ready                  decode -> fetch accept
//  Modports    : master = fetch unit, slave = surrounding pipeline/memory
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import isa_pkg::*;

    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              halt;
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [INST_W-1:0] if_inst;
    logic              id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_inst,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, halt, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_inst,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, halt, id_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Small circular FIFO of {pc, inst} entries between the
//                instruction-memory response and the decoder. Push and pop
//                in the same cycle are both honoured (push is allowed while
//                full if a pop frees a slot). Flush empties it at once.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                i_push/i_push_entry write one entry
//                i_pop               remove head entry
//                i_flush             discard all entries (wins over push/pop)
//                o_head              head entry (undefined while empty)
//                o_full/o_empty/o_count occupancy status
//  Parameters  : DEPTH (power of two: 2 or 4), CNT_W occupancy width
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import isa_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire fetch_entry_t     i_push_entry,
    input  wire logic             i_pop,
    input  wire logic             i_flush,
    output fetch_entry_t          o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CNT_W-1:0]      o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_pop;
    logic               w_do_push;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues word-addressed sequential
//                reads to instruction memory (response exactly one cycle
//                later), buffers responses with their PC tag and hands them
//                to the decoder. Redirects flush the buffer and mark any
//                in-flight response stale through a one-bit epoch.
//                An arriving response is shown to the decoder in the same
//                cycle when the buffer is empty, giving a two-cycle
//                redirect-to-instruction latency.
//  Ports       : clk   single clock, rising edge
//                reset synchronous active-high reset
//                bus   fetch_unit_if.master (memory, redirect, halt, decode)
//  Parameters  : RESET_PC  PC loaded by reset
//                BUF_DEPTH instruction buffer entries (2 or 4)
//  Macros      : FETCH_JMP_PREDECODE_EN - when defined, JMP words are
//                recognised on arrival and fetch jumps to their target.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import isa_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    fetch_unit_if.master   bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    logic [31:0]        r_pc;
    logic               r_epoch;
    logic               r_pend;        // request issued last cycle
    logic               r_pend_epoch;  // epoch that request was issued in
    logic [31:0]        r_pend_pc;     // address of that request
    logic               r_rst_d1;      // reset was active last cycle

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic               w_issue;
    logic               w_room;
    logic               w_rsp_ok;
    logic               w_push;
    logic               w_pop;
    logic               w_jmp_taken;
    logic [31:0]        w_jmp_pc;

    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;
    logic               w_buf_full;
    logic               w_buf_empty;
    logic [CNT_W-1:0]   w_buf_count;

    // A response is usable only if it belongs to the current epoch and is not
    // overtaken by a redirect in this very cycle; anything near reset is dropped.
    assign w_rsp_ok = bus.imem_rvalid && r_pend && (r_pend_epoch == r_epoch)
                      && !reset && !r_rst_d1 && !bus.redirect_valid;

    // When the buffer is empty and decode accepts, the response bypasses it.
    assign w_push = w_rsp_ok && !(w_buf_empty && bus.id_ready);
    assign w_pop  = !w_buf_empty && bus.id_ready && !bus.redirect_valid;

    assign w_push_entry = '{pc: r_pend_pc, inst: bus.imem_rdata};

`ifdef FETCH_JMP_PREDECODE_EN
    assign w_jmp_taken = w_rsp_ok && is_jmp(bus.imem_rdata[31:26]);
    assign w_jmp_pc    = jmp_target(r_pend_pc[31:26], bus.imem_rdata[25:0]);
`else
    assign w_jmp_taken = 1'b0;
    assign w_jmp_pc    = r_pend_pc;
`endif

    // Count the in-flight request as occupied so a response always has a slot
    assign w_room = ({1'b0, w_buf_count} + {{CNT_W{1'b0}}, r_pend})
                    < (CNT_W + 1)'(BUF_DEPTH);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (redirect outranks halt)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.redirect_valid && bus.halt) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!bus.halt || bus.redirect_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_issue = 1'b0;
        if ((r_state == ST_RUN) && w_room && !w_buf_full && !reset) begin
            w_issue = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // PC, epoch and in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_epoch      <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_epoch <= 1'b0;
            r_pend_pc    <= '0;
            r_rst_d1     <= 1'b1;
        end else begin
            r_rst_d1 <= 1'b0;
            r_pend   <= w_issue;
            if (w_issue) begin
                r_pend_pc    <= r_pc;
                r_pend_epoch <= r_epoch;
            end

            if (bus.redirect_valid) begin
                r_pc <= bus.redirect_pc;
            end else if (w_jmp_taken) begin
                r_pc <= w_jmp_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd1;
            end

            // New epoch makes the request issued this cycle (if any) stale
            if (bus.redirect_valid || w_jmp_taken) begin
                r_epoch <= ~r_epoch;
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer
    // ------------------------------------------------------------------
    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk          (clk),
        .rst          (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_flush      (bus.redirect_valid),
        .o_head       (w_head),
        .o_full       (w_buf_full),
        .o_empty      (w_buf_empty),
        .o_count      (w_buf_count)
    );

    // ------------------------------------------------------------------
    // Bus outputs (forced to their reset values while reset is high)
    // ------------------------------------------------------------------
    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = reset ? RESET_PC : r_pc;

    assign bus.if_valid  = !reset && (!w_buf_empty || w_rsp_ok);
    assign bus.if_pc     = reset        ? 32'd0        :
                           !w_buf_empty ? w_head.pc    : r_pend_pc;
    assign bus.if_inst   = reset        ? '0           :
                           !w_buf_empty ? w_head.inst  : bus.imem_rdata;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded by reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; legal values 2 or 4.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  read request to instruction memory this cycle.
REQ-006 imem_addr  out  32  word address of request.
REQ-007 imem_rvalid  in  1  read data valid; exactly 1 cycle after an accepted imem_req.
REQ-008 imem_rdata  in  32  instruction word.
REQ-009 redirect_valid  in  1  control-flow change (branch/JMP/CALL/RET) from later stages.
REQ-010 redirect_pc  in  32  target word address.
REQ-011 halt  in  1  stop issuing new requests.
REQ-012 if_valid  out  1  if_pc/if_inst hold an instruction for decode.
REQ-013 if_pc  out  32  word address of if_inst.
REQ-014 if_inst  out  32  instruction word to decoder.
REQ-015 id_ready  in  1  decoder accepts; transfer when if_valid && id_ready.

Function
REQ-016 PC is word-addressed; sequential next PC = PC + 1, wrapping 32'hFFFF_FFFF -> 0.
REQ-017 FSM states: BOOT, RUN, HALTED. BOOT -> RUN after one cycle with no request. RUN -> HALTED when halt=1. HALTED -> RUN when halt=0 or redirect_valid=1.
REQ-018 In RUN, imem_req=1 only when (buffer occupancy + outstanding requests) < BUF_DEPTH; imem_addr=PC; PC advances on each request.
REQ-019 Each response is written to the buffer with its PC tag; the buffer never overflows.
REQ-020 Buffer head drives if_valid/if_pc/if_inst; while if_valid=1 and id_ready=0, all three outputs stay stable.
REQ-021 Simultaneous buffer write and head pop in one cycle are both performed; occupancy stays unchanged.
REQ-022 redirect_valid=1 flushes the buffer and drops if_valid the next cycle.
REQ-023 redirect_valid=1 also tags the outstanding response stale via an epoch bit; the stale response is discarded on arrival.
REQ-024 redirect_valid=1 loads PC=redirect_pc and allows a request at redirect_pc in the following cycle.
REQ-025 Redirect has priority over halt, buffer pop and any predecode redirect in the same cycle.
REQ-026 Redirect-to-first-instruction latency: redirect cycle N, request N+1, if_valid N+2.
REQ-027 Halt stops new requests only; outstanding responses still complete and drain to the decoder.

Reset
REQ-028 During reset: PC=RESET_PC, state=BOOT, buffer empty, epoch=0, outstanding=0.
REQ-029 During reset: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0.
REQ-030 Reset mid-operation discards any in-flight response; imem_rvalid is ignored in the reset cycle and the cycle after.

Configuration
REQ-031 Macro FETCH_JMP_PREDECODE_EN, when defined: on a non-stale response with opcode imem_rdata[31:26]=6'b001100 (JMP), the JMP is buffered and PC is set to {tag_pc[31:26], imem_rdata[25:0]}.
REQ-032 With FETCH_JMP_PREDECODE_EN defined, the sequential request issued after the JMP is discarded by epoch.
REQ-033 With FETCH_JMP_PREDECODE_EN undefined, fetch is purely sequential and JMP is resolved only via redirect_valid.

Structure
REQ-034 Shared package isa_pkg holds: OP_JMP=6'b001100, OP_CALL=6'b001101, OP_PUSH=6'b001111, OP_POP=6'b010000, the FSM state encodings, and the instruction width (32).
REQ-035 Sub-module fetch_buffer: parameterised FIFO of {pc, inst}, depth BUF_DEPTH, push/pop/flush ports, full/empty/count outputs.

Verification
REQ-036 Reset with RESET_PC=0x100, id_ready=1, memory returns the address as data -> if_pc sequence 0x100,0x101,0x102 with one output per cycle after a 3-cycle start-up.
REQ-037 id_ready=0 for 5 cycles -> at most BUF_DEPTH requests outstanding or buffered, if_pc/if_inst frozen, no loss or duplication after release.
REQ-038 redirect_pc=0x400 while a response for 0x105 is in flight -> 0x105 never appears, next if_pc=0x400 two cycles after redirect.
REQ-039 halt=1 in RUN -> imem_req=0 next cycle, buffered instructions drain; halt=0 -> fetch resumes at the next sequential PC.
REQ-040 FETCH_JMP_PREDECODE_EN defined, JMP 0x30000020 fetched at PC 0x0C000010 -> if_pc sequence 0x0C000010 then 0x0C000020; PC 0x0C000011 is never output.
REQ-041 PC=0xFFFFFFFF, sequential fetch -> next if_pc=0x00000000.
